matrix_bus_master: RTL and testbench
====================================

MATRIX_BUS_MASTER -- requirements
Module: matrix_bus_master

Interface
REQ-001 The block SHALL expose parameter BUS_W, default 262, meaning shared data/address bus width.
REQ-002 The block SHALL expose parameter ADDR_W, default 7, meaning responder address width carried in bus[ADDR_W-1:0].
REQ-003 The block SHALL use the reset reset, asynchronous, active-high; clock clock.
REQ-004 The block SHALL have the following ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_target  in  2  0 = instruction memory, 1 = matrix memory, 2 = registers, 3 = invalid
- req_addr  in  ADDR_W  responder address
- req_overflow  in  1  forwarded to responder overflow (write to addr+1)
- req_wdata  in  BUS_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  BUS_W  captured read data
- rsp_err  out  1  transaction rejected or verify failure
- bus  inout  BUS_W  shared tristate bus
- import_address  out  1  address-latch strobe, rising edge significant
- read  out  1  responder drive enable
- write  out  1  responder write strobe, sampled on clock rising edge
- overflow  out  1  responder overflow
- enable  out  3  one-hot responder select, bit n = target n

Function
REQ-005 All strobes, enable, overflow and rsp_* SHALL be registered; bus SHALL be high-Z except in ADDR, LATCH, WR_SETUP and WR_PULSE.
REQ-006 States SHALL be IDLE, ADDR, LATCH, RD, RD_CAP, WR_SETUP, WR_PULSE, RESP (plus VRD and VCAP under REQ-016).
REQ-007 IDLE: req_ready=1; on req_valid&&req_ready, latch all req_* fields and go to ADDR; req_ready=0 in every other state.
REQ-008 ADDR: drive bus={zeros, addr}, enable[target]=1, import_address=0. LATCH: same bus value, import_address=1.
REQ-009 Read path: RD releases bus, import_address=0, read=1; RD_CAP keeps read=1 and captures bus into rsp_rdata at the end of the cycle; then RESP.
REQ-010 Write path: WR_SETUP drives req_wdata with overflow set and write=0; WR_PULSE asserts write=1 for exactly one cycle; then RESP with write=0.
REQ-011 enable[target] SHALL remain high from ADDR through the last bus state and drop on entry to RESP.
REQ-012 RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_ready; on rsp_ready go to IDLE, so back-to-back requests are possible one cycle after the handshake.
REQ-013 Latency SHALL be exactly 5 cycles from the accept edge to rsp_valid for both reads and writes (without REQ-016).
REQ-014 target=3, or a write with target=0, SHALL go directly to RESP with rsp_err=1, no strobes, bus high-Z, and rsp_rdata unchanged.
REQ-015 Writes SHALL return rsp_rdata unchanged; a successful transaction SHALL return rsp_err=0.

Configuration
REQ-016 With MATRIX_BUS_VERIFY_EN defined, a write SHALL proceed WR_PULSE -> VRD -> VCAP, identical to RD and RD_CAP, compare the captured data with wdata, set rsp_err on mismatch, and have a latency of 7 cycles; the overflow write is compared against the same address without re-latching. Without the macro, VRD and VCAP SHALL not exist.

Reset
REQ-017 Reset SHALL immediately force state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, all strobes/enable/overflow=0 and bus high-Z, including mid-transaction.
REQ-018 A transaction interrupted by reset SHALL be discarded with no response.

Structure
REQ-019 Package matrix_bus_pkg SHALL hold the state enum, target codes (TGT_INSTR, TGT_MATRIX, TGT_REGS) and the width constants.
REQ-020 One sub-module, matrix_bus_drv, SHALL hold the bus tristate driver (drive value plus output-enable).

Verification
REQ-021 Read target=1, addr=5, with responder preloaded with 0xABC -> import_address rises in cycle 2, rsp_valid in cycle 5, rsp_rdata=0xABC, rsp_err=0.
REQ-022 Write target=2, addr=3, wdata=0x55, then read it back -> write high for exactly 1 cycle, readback 0x55.
REQ-023 Write target=0 and, separately, read target=3 -> rsp_err=1 the next cycle, no strobe toggles, bus high-Z throughout.
REQ-024 Reset asserted during WR_PULSE -> write=0 and bus high-Z immediately, rsp_valid never asserts, next request behaves normally.
REQ-025 Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; the request queued behind it is accepted the cycle after the handshake.
REQ-026 With MATRIX_BUS_VERIFY_EN defined, force the responder to corrupt bit 0 -> rsp_err=1 at cycle 7.

Source files
------------

// File: rtl/matrix_bus_pkg.sv
// -----------------------------------------------------------------------------
// matrix_bus_pkg
// Shared definitions for the matrix bus master: FSM state encoding, responder
// target codes, default bus/address widths and the target-to-enable decoder.
// Optional build macro: MATRIX_BUS_VERIFY_EN adds the VRD/VCAP write-verify
// states to the state enum.
// -----------------------------------------------------------------------------
package matrix_bus_pkg;

  localparam int MB_BUS_W  = 262;
  localparam int MB_ADDR_W = 7;
  localparam int MB_TGT_W  = 2;
  localparam int MB_EN_W   = 3;

  localparam logic [MB_TGT_W-1:0] TGT_INSTR  = 2'd0;
  localparam logic [MB_TGT_W-1:0] TGT_MATRIX = 2'd1;
  localparam logic [MB_TGT_W-1:0] TGT_REGS   = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    LATCH,
    RD,
    RD_CAP,
    WR_SETUP,
    WR_PULSE,
    RESP
`ifdef MATRIX_BUS_VERIFY_EN
    ,
    VRD,
    VCAP
`endif
  } state_t;

  // One-hot responder select; code 3 has no responder and selects nothing.
  function automatic logic [MB_EN_W-1:0] tgt_onehot(input logic [MB_TGT_W-1:0] tgt);
    case (tgt)
      TGT_INSTR:  tgt_onehot = 3'b001;
      TGT_MATRIX: tgt_onehot = 3'b010;
      TGT_REGS:   tgt_onehot = 3'b100;
      default:    tgt_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/matrix_bus_drv.sv
// -----------------------------------------------------------------------------
// matrix_bus_drv
// Tristate driver for the shared data/address bus.
// Ports:
//   i_data  in     BUS_W  value to drive
//   i_oe    in     1      output enable; bus floats when low
//   io_bus  inout  BUS_W  shared bus
// -----------------------------------------------------------------------------
module matrix_bus_drv #(
  parameter int BUS_W = 262
) (
  input  logic [BUS_W-1:0] i_data,
  input  logic             i_oe,
  inout  wire  [BUS_W-1:0] io_bus
);

  assign io_bus = i_oe ? i_data : {BUS_W{1'bz}};

endmodule

// File: rtl/matrix_bus_master.sv
// -----------------------------------------------------------------------------
// matrix_bus_master
// Turns single read/write requests into the address-latch / read / write
// strobe sequence of the shared tristate bus and returns one response each.
// Ports:
//   clock, reset         clock, async active-high reset
//   req_valid/req_ready  request handshake; req_write, req_target, req_addr,
//                        req_overflow, req_wdata are the request fields
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err are the result
//   bus                  shared tristate data/address bus
//   import_address, read, write, overflow, enable   responder strobes/select
// Optional build macro: MATRIX_BUS_VERIFY_EN reads every write back (VRD/VCAP)
// and flags rsp_err when the readback differs from the written data.
// -----------------------------------------------------------------------------
module matrix_bus_master
  import matrix_bus_pkg::*;
#(
  parameter int BUS_W  = MB_BUS_W,
  parameter int ADDR_W = MB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_target,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_overflow,
  input  logic [BUS_W-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BUS_W-1:0]  rsp_rdata,
  output logic              rsp_err,
  inout  wire  [BUS_W-1:0]  bus,
  output logic              import_address,
  output logic              read,
  output logic              write,
  output logic              overflow,
  output logic [2:0]        enable
);

  state_t r_state, w_next;

  logic              r_write, r_ovf;
  logic [1:0]        r_target;
  logic [ADDR_W-1:0] r_addr;
  logic [BUS_W-1:0]  r_wdata;

  logic              r_req_ready, r_rsp_valid, r_rsp_err;
  logic              r_import, r_read, r_wstb, r_overflow, r_bus_oe;
  logic [2:0]        r_enable;
  logic [BUS_W-1:0]  r_rsp_rdata, r_bus_data;

  logic              w_accept, w_reject, w_resp_err;
  logic              w_import, w_read, w_wstb, w_ovf, w_oe;
  logic [2:0]        w_en;
  logic [1:0]        w_tgt;
  logic [ADDR_W-1:0] w_addr;
  logic [BUS_W-1:0]  w_bus_data;

  always_comb begin
    w_accept = (r_state == IDLE) && req_valid;
    w_reject = (req_target == 2'd3) || (req_write && (req_target == TGT_INSTR));
    // On the accept edge the request registers are still loading, so the
    // first registered bus/enable values come straight from the inputs.
    w_tgt    = (r_state == IDLE) ? req_target : r_target;
    w_addr   = (r_state == IDLE) ? req_addr   : r_addr;

    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = w_reject ? RESP : ADDR;
      ADDR:     w_next = LATCH;
      LATCH:    w_next = r_write ? WR_SETUP : RD;
      RD:       w_next = RD_CAP;
      RD_CAP:   w_next = RESP;
      WR_SETUP: w_next = WR_PULSE;
`ifdef MATRIX_BUS_VERIFY_EN
      WR_PULSE: w_next = VRD;
      VRD:      w_next = VCAP;
      VCAP:     w_next = RESP;
`else
      WR_PULSE: w_next = RESP;
`endif
      RESP:     if (rsp_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so every
    // strobe lines up with the state it belongs to.
    w_en       = '0;
    w_import   = 1'b0;
    w_read     = 1'b0;
    w_wstb     = 1'b0;
    w_ovf      = 1'b0;
    w_oe       = 1'b0;
    w_bus_data = '0;
    case (w_next)
      ADDR, LATCH: begin
        w_en                   = tgt_onehot(w_tgt);
        w_oe                   = 1'b1;
        w_bus_data[ADDR_W-1:0] = w_addr;
        w_import               = (w_next == LATCH);
      end
      RD, RD_CAP: begin
        w_en   = tgt_onehot(r_target);
        w_read = 1'b1;
      end
      WR_SETUP, WR_PULSE: begin
        w_en       = tgt_onehot(r_target);
        w_oe       = 1'b1;
        w_bus_data = r_wdata;
        w_ovf      = r_ovf;
        w_wstb     = (w_next == WR_PULSE);
      end
`ifdef MATRIX_BUS_VERIFY_EN
      // Keep overflow so the readback hits the location just written.
      VRD, VCAP: begin
        w_en   = tgt_onehot(r_target);
        w_read = 1'b1;
        w_ovf  = r_ovf;
      end
`endif
      default: ;
    endcase

    // Only the reject path goes IDLE -> RESP.
    w_resp_err = (r_state == IDLE);
`ifdef MATRIX_BUS_VERIFY_EN
    if (r_state == VCAP) w_resp_err = (bus != r_wdata);
`endif
  end

  // ---- control / response registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_import    <= 1'b0;
      r_read      <= 1'b0;
      r_wstb      <= 1'b0;
      r_overflow  <= 1'b0;
      r_enable    <= '0;
      r_bus_oe    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == IDLE);
      r_rsp_valid <= (w_next == RESP);
      if ((w_next == RESP) && (r_state != RESP)) r_rsp_err <= w_resp_err;
      if (r_state == RD_CAP) r_rsp_rdata <= bus;
      r_import    <= w_import;
      r_read      <= w_read;
      r_wstb      <= w_wstb;
      r_overflow  <= w_ovf;
      r_enable    <= w_en;
      r_bus_oe    <= w_oe;
    end
  end

  // ---- request fields and bus drive value ----
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_write  <= req_write;
      r_target <= req_target;
      r_addr   <= req_addr;
      r_ovf    <= req_overflow;
      r_wdata  <= req_wdata;
    end
    r_bus_data <= w_bus_data;
  end

  matrix_bus_drv #(.BUS_W(BUS_W)) u_drv (
    .i_data (r_bus_data),
    .i_oe   (r_bus_oe),
    .io_bus (bus)
  );

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_err        = r_rsp_err;
  assign rsp_rdata      = r_rsp_rdata;
  assign import_address = r_import;
  assign read           = r_read;
  assign write          = r_wstb;
  assign overflow       = r_overflow;
  assign enable         = r_enable;

endmodule

// File: tb/tb_matrix_bus_master.sv
// -----------------------------------------------------------------------------
// tb_matrix_bus_master
// Bench for matrix_bus_master with a behavioural three-target responder.
// Expected responses go into a scoreboard queue when a request is accepted and
// are compared when the DUT presents the response.
// Honours MATRIX_BUS_VERIFY_EN (write latency 7 and corrupted readback check).
// -----------------------------------------------------------------------------
module tb_matrix_bus_master;

  localparam int BUS_W  = 262;
  localparam int ADDR_W = 7;
`ifdef MATRIX_BUS_VERIFY_EN
  localparam int WR_LAT = 7;
`else
  localparam int WR_LAT = 5;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid, req_write, req_overflow, rsp_ready;
  logic [1:0]        req_target;
  logic [ADDR_W-1:0] req_addr;
  logic [BUS_W-1:0]  req_wdata;
  logic              req_ready, rsp_valid, rsp_err;
  logic              import_address, read, write, overflow;
  logic [2:0]        enable;
  logic [BUS_W-1:0]  rsp_rdata;
  wire  [BUS_W-1:0]  bus;

  always #5 clock = ~clock;

  matrix_bus_master #(.BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_target     (req_target),
    .req_addr       (req_addr),
    .req_overflow   (req_overflow),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .bus            (bus),
    .import_address (import_address),
    .read           (read),
    .write          (write),
    .overflow       (overflow),
    .enable         (enable)
  );

  // ---- behavioural responder ----
  logic [BUS_W-1:0]  mem [0:2][0:127];
  logic [ADDR_W-1:0] rs_addr = '0;
  logic [2:0]        rs_sel  = '0;
  logic              corrupt = 1'b0;
  int                sel_i;
  logic [ADDR_W-1:0] acc_addr;
  logic [BUS_W-1:0]  rd_val;

  always_comb begin
    sel_i    = rs_sel[2] ? 2 : (rs_sel[1] ? 1 : 0);
    acc_addr = rs_addr + ADDR_W'(overflow);
    rd_val   = mem[sel_i][acc_addr] ^ {{(BUS_W-1){1'b0}}, corrupt};
  end

  assign bus = read ? rd_val : {BUS_W{1'bz}};

  always @(posedge import_address) begin
    rs_addr = bus[ADDR_W-1:0];
    rs_sel  = enable;
  end

  always @(posedge clock) if (write) mem[sel_i][acc_addr] <= bus;

  // ---- checking ----
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [BUS_W-1:0] rd;
    logic             err;
  } sb_t;
  sb_t sb_q[$];

  logic [BUS_W-1:0] last_rd;

  task automatic run_txn(input string nm, input logic wr, input logic [1:0] tgt,
                         input logic [ADDR_W-1:0] a, input logic ovf, input logic [BUS_W-1:0] wd,
                         input logic [BUS_W-1:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_imp, input int exp_wr, input int exp_oe,
                         input int hold);
    int wait_n, cyc, imp_cyc, wr_cyc, strb, oe_cyc;
    logic stable;
    logic [BUS_W-1:0] first_rd;
    logic first_err;
    sb_t exp;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_target = tgt; req_addr = a;
    req_overflow = ovf; req_wdata = wd;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin @(negedge clock); wait_n++; end
    check({nm, "_accept_wait"}, wait_n, 0);
    @(posedge clock);
    sb_q.push_back('{rd: exp_rd, err: exp_err});
    #1 req_valid = 1'b0;
    cyc = 0; imp_cyc = 0; wr_cyc = 0; strb = 0; oe_cyc = 0;
    while (cyc < 30) begin
      @(negedge clock);
      cyc++;
      if (import_address && imp_cyc == 0) imp_cyc = cyc;
      if (write) wr_cyc++;
      if (import_address || read || write || overflow || enable != 3'b000) strb++;
      if (dut.r_bus_oe) oe_cyc++;
      if (rsp_valid) break;
    end
    check({nm, "_latency"}, cyc, exp_lat);
    check({nm, "_import_cycle"}, imp_cyc, exp_imp);
    check({nm, "_write_cycles"}, wr_cyc, exp_wr);
    check({nm, "_bus_drive_cycles"}, oe_cyc, exp_oe);
    if (exp_lat == 1) check({nm, "_strobe_cycles"}, strb, 0);
    first_rd = rsp_rdata; first_err = rsp_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!rsp_valid || rsp_rdata !== first_rd || rsp_err !== first_err || req_ready) stable = 1'b0;
    end
    if (hold > 0) check({nm, "_hold_stable"}, stable, 1);
    exp = sb_q.pop_front();
    check({nm, "_rdata"}, rsp_rdata, exp.rd);
    check({nm, "_err"}, rsp_err, exp.err);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    check({nm, "_rsp_drop"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUS_W-1:0] wpat;
    for (int t = 0; t < 3; t++)
      for (int j = 0; j < 128; j++) mem[t][j] <= '0;
    #1;
    mem[1][5] <= BUS_W'(12'hABC);
    mem[2][9] <= BUS_W'(16'h1234);
    wpat = '0;
    for (int i = 0; i < BUS_W; i += 32) wpat = (wpat << 32) | BUS_W'($urandom());

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_target = '0;
    req_addr = '0; req_overflow = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_strobes", {import_address, read, write, overflow, enable}, 0);
    check("rst_bus_oe", dut.r_bus_oe, 0);
    reset = 1'b0;
    last_rd = '0;

    run_txn("rd_m5", 0, 2'd1, 7'd5, 0, '0, BUS_W'(12'hABC), 0, 5, 2, 0, 2, 0);
    last_rd = BUS_W'(12'hABC);
    run_txn("wr_r3", 1, 2'd2, 7'd3, 0, BUS_W'(8'h55), last_rd, 0, WR_LAT, 2, 1, 4, 0);
    run_txn("rd_r3", 0, 2'd2, 7'd3, 0, '0, BUS_W'(8'h55), 0, 5, 2, 0, 2, 0);
    last_rd = BUS_W'(8'h55);
    run_txn("wr_instr", 1, 2'd0, 7'd4, 0, BUS_W'(8'h11), last_rd, 1, 1, 0, 0, 0, 0);
    run_txn("rd_tgt3", 0, 2'd3, 7'd4, 0, '0, last_rd, 1, 1, 0, 0, 0, 0);
    run_txn("wr_ovf", 1, 2'd1, 7'd10, 1, wpat, last_rd, 0, WR_LAT, 2, 1, 4, 0);
    run_txn("rd_ovf", 0, 2'd1, 7'd11, 0, '0, wpat, 0, 5, 2, 0, 2, 0);
    last_rd = wpat;
    run_txn("rd_hold", 0, 2'd2, 7'd3, 0, '0, BUS_W'(8'h55), 0, 5, 2, 0, 2, 10);
    last_rd = BUS_W'(8'h55);
    run_txn("rd_b2b", 0, 2'd1, 7'd5, 0, '0, BUS_W'(12'hABC), 0, 5, 2, 0, 2, 0);
    last_rd = BUS_W'(12'hABC);

    // Reset in the middle of the write pulse.
    begin
      logic no_rsp;
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_target = 2'd2; req_addr = 7'd9;
      req_overflow = 1'b0; req_wdata = BUS_W'(8'h77);
      check("mid_accept_ready", req_ready, 1);
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clock);
      check("mid_write_pulse", write, 1);
      #2 reset = 1'b1;
      #1;
      check("mid_write_low", write, 0);
      check("mid_bus_oe", dut.r_bus_oe, 0);
      check("mid_enable", enable, 0);
      check("mid_req_ready", req_ready, 1);
      check("mid_rsp_rdata", rsp_rdata, 0);
      @(negedge clock);
      reset = 1'b0;
      no_rsp = 1'b1;
      repeat (8) begin @(negedge clock); if (rsp_valid) no_rsp = 1'b0; end
      check("mid_no_response", no_rsp, 1);
      last_rd = '0;
    end
    run_txn("rd_after_rst", 0, 2'd2, 7'd9, 0, '0, BUS_W'(16'h1234), 0, 5, 2, 0, 2, 0);
    last_rd = BUS_W'(16'h1234);

`ifdef MATRIX_BUS_VERIFY_EN
    corrupt = 1'b1;
    run_txn("vfy_corrupt", 1, 2'd2, 7'd20, 0, BUS_W'(8'h99), last_rd, 1, 7, 2, 1, 4, 0);
    corrupt = 1'b0;
    run_txn("vfy_clean", 1, 2'd2, 7'd21, 0, BUS_W'(8'h3C), last_rd, 0, 7, 2, 1, 4, 0);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
